// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// kbd_pkg : shared keyboard matrix geometry, frame size and FSM state type
// Rev 1.0
// ============================================================================
package kbd_pkg;

  localparam int KBD_ROWS       = 8;
  localparam int KBD_COLS       = 5;
  localparam int KBD_FRAME_BITS = 48;

  // Bit positions within the extras byte; bits 3..7 are reserved.
  localparam int EXT_MAGIC      = 0;
  localparam int EXT_RESET_REQ  = 1;
  localparam int EXT_TURBO      = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } kbd_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ============================================================================
// spi_in_sync : synchronizers and registered edge pulses for the keyboard SPI pins
// Rev 1.0
// ============================================================================
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK_14MHZ,
  input  logic CPU_RESET,
  input  logic cs_pin,
  input  logic sclk_pin,
  input  logic di_pin,
  output logic cs_fall,
  output logic cs_rise,
  output logic sclk_rise,
  output logic di_bit
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] di_sync;
  logic                   cs_prev;
  logic                   sclk_prev;

  // Edge pulses and the data tap are registered together so a sampled bit
  // always lines up with its clock pulse, SYNC_STAGES+1 clocks after the pins.
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      di_sync   <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      sclk_rise <= 1'b0;
      di_bit    <= 1'b0;
    end else begin
      cs_sync[0]   <= cs_pin;
      sclk_sync[0] <= sclk_pin;
      di_sync[0]   <= di_pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i]   <= cs_sync[i-1];
        sclk_sync[i] <= sclk_sync[i-1];
        di_sync[i]   <= di_sync[i-1];
      end
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_fall   <= cs_prev & ~cs_sync[SYNC_STAGES-1];
      cs_rise   <= ~cs_prev & cs_sync[SYNC_STAGES-1];
      sclk_rise <= ~sclk_prev & sclk_sync[SYNC_STAGES-1];
      di_bit    <= di_sync[SYNC_STAGES-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_spi_matrix_rx.sv
`default_nettype none
// ============================================================================
// kbd_spi_matrix_rx : SPI keyboard frame receiver, atomic matrix commit, port #FE column mux
// Rev 1.0
// ============================================================================
module kbd_spi_matrix_rx
  import kbd_pkg::*;
#(
  parameter int MATRIX_BITS = 40,
  parameter int EXTRA_BITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK_14MHZ,
  input  logic                  CPU_RESET,
  input  logic                  KBD_CS,
  input  logic                  KBD_CLK,
  input  logic                  KBD_DI,
  input  logic [KBD_ROWS-1:0]   A_HI,
  output logic [KBD_COLS-1:0]   KD,
  output logic [EXTRA_BITS-1:0] EXT_KEYS,
  output logic                  FRAME_OK,
  output logic                  FRAME_ERR
);

  localparam int FRAME_BITS = MATRIX_BITS + EXTRA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

  logic cs_fall;
  logic cs_rise;
  logic sclk_rise;
  logic di_bit;

  spi_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK_14MHZ (CLK_14MHZ),
    .CPU_RESET (CPU_RESET),
    .cs_pin    (KBD_CS),
    .sclk_pin  (KBD_CLK),
    .di_pin    (KBD_DI),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .sclk_rise (sclk_rise),
    .di_bit    (di_bit)
  );

  kbd_state_t             state;
  kbd_state_t             state_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  shreg;
  logic [MATRIX_BITS-1:0] matrix;
  logic [MATRIX_BITS-1:0] frame_matrix;
  logic                   clr_cnt;
  logic                   shift_en;
  logic                   commit;
  logic                   discard;

  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // A CS rise outranks a coincident SCLK rise; a CS fall inside a frame restarts it.
  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    discard   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_nxt = ST_SHIFT;
          clr_cnt   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_nxt = ST_IDLE;
          if (bit_cnt == CNT_FULL) commit  = 1'b1;
          else                     discard = 1'b1;
        end else if (cs_fall) begin
          clr_cnt = 1'b1;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // First wire bit ends up at the top of the shift register.
  for (genvar i = 0; i < MATRIX_BITS; i++) begin : g_unpack
    assign frame_matrix[i] = shreg[FRAME_BITS-1-i];
  end

  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      matrix    <= '1;
      EXT_KEYS  <= '0;
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_OK  <= commit;
      FRAME_ERR <= discard;
      if (clr_cnt) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        shreg <= {shreg[FRAME_BITS-2:0], di_bit};
        if (bit_cnt != CNT_OVF) bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (commit) begin
        matrix   <= frame_matrix;
        EXT_KEYS <= shreg[EXTRA_BITS-1:0];
      end
    end
  end

  always_comb begin
    KD = '1;
    for (int r = 0; r < KBD_ROWS; r++) begin
      if (!A_HI[r]) KD = KD & matrix[r*KBD_COLS +: KBD_COLS];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_spi_matrix_rx.sv
`default_nettype none
// ============================================================================
// tb_kbd_spi_matrix_rx : directed frame and KD-table checks for kbd_spi_matrix_rx
// Rev 1.0
// ============================================================================
module tb_kbd_spi_matrix_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kbd_cs;
  logic       kbd_clk;
  logic       kbd_di;
  logic [7:0] a_hi;
  logic [4:0] kd;
  logic [7:0] ext_keys;
  logic       frame_ok;
  logic       frame_err;

  int n_total = 0;
  int n_pass  = 0;
  int ok_cnt  = 0;
  int err_cnt = 0;

  always #35 clk = ~clk;

  kbd_spi_matrix_rx dut (
    .CLK_14MHZ (clk),
    .CPU_RESET (rst_n),
    .KBD_CS    (kbd_cs),
    .KBD_CLK   (kbd_clk),
    .KBD_DI    (kbd_di),
    .A_HI      (a_hi),
    .KD        (kd),
    .EXT_KEYS  (ext_keys),
    .FRAME_OK  (frame_ok),
    .FRAME_ERR (frame_err)
  );

  always @(negedge clk) begin
    if (frame_ok)  ok_cnt  <= ok_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    logic [7:0] a;
    logic [4:0] kd;
  } kd_vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_kd(input string nm, input logic [7:0] a, input logic [4:0] exp);
    a_hi = a;
    #1;
    check(nm, {27'd0, kd}, {27'd0, exp});
  endtask

  // Wire bit i of the returned vector is the i-th bit sent; extras go MSB first.
  function automatic logic [63:0] mk_frame(input logic [39:0] m, input logic [7:0] e);
    logic [63:0] f;
    f = '1;
    for (int i = 0; i < 40; i++) f[i] = m[i];
    for (int j = 0; j < 8; j++) f[40+j] = e[7-j];
    return f;
  endfunction

  function automatic logic [39:0] keys(input int k0, input int k1, input int k2);
    logic [39:0] m;
    m = '1;
    if (k0 >= 0) m[k0] = 1'b0;
    if (k1 >= 0) m[k1] = 1'b0;
    if (k2 >= 0) m[k2] = 1'b0;
    return m;
  endfunction

  // mode 0: raise CS after the frame; 1: raise CS together with the last SCLK rise;
  // 2: leave CS low.
  task automatic send(input logic [63:0] f, input int n, input int mode);
    kbd_cs = 1'b0;
    cyc(8);
    for (int i = 0; i < n; i++) begin
      kbd_di = f[i];
      cyc(5);
      if (mode == 1 && i == n - 1) kbd_cs = 1'b1;
      kbd_clk = 1'b1;
      cyc(5);
      kbd_clk = 1'b0;
    end
    cyc(5);
    if (mode == 0) kbd_cs = 1'b1;
    if (mode != 2) cyc(10);
  endtask

  kd_vec_t rst_tab[10];
  kd_vec_t multi_tab[7];

  initial begin
    int ok0;
    int err0;

    rst_tab[0] = '{8'hFE, 5'h1F}; rst_tab[1] = '{8'hFD, 5'h1F};
    rst_tab[2] = '{8'hFB, 5'h1F}; rst_tab[3] = '{8'hF7, 5'h1F};
    rst_tab[4] = '{8'hEF, 5'h1F}; rst_tab[5] = '{8'hDF, 5'h1F};
    rst_tab[6] = '{8'hBF, 5'h1F}; rst_tab[7] = '{8'h7F, 5'h1F};
    rst_tab[8] = '{8'h00, 5'h1F}; rst_tab[9] = '{8'hFF, 5'h1F};
    // Keys r0c0, r3c2, r7c4 pressed.
    multi_tab[0] = '{8'hFE, 5'h1E}; multi_tab[1] = '{8'hF7, 5'h1B};
    multi_tab[2] = '{8'h7F, 5'h0F}; multi_tab[3] = '{8'hF6, 5'h1A};
    multi_tab[4] = '{8'h00, 5'h0A}; multi_tab[5] = '{8'hFF, 5'h1F};
    multi_tab[6] = '{8'hFD, 5'h1F};

    rst_n = 1'b0; kbd_cs = 1'b1; kbd_clk = 1'b0; kbd_di = 1'b0; a_hi = 8'hFF;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    foreach (rst_tab[i]) check($sformatf("reset_kd_%02h", rst_tab[i].a), {27'd0, kd_probe(rst_tab[i].a)}, {27'd0, rst_tab[i].kd});
    check("reset_ext", {24'd0, ext_keys}, 32'h00);
    check("reset_ok_pulses", ok_cnt, 0);
    check("reset_err_pulses", err_cnt, 0);

    // CAPS SHIFT frame, with commit latency measured from the CS pin rise.
    a_hi = 8'hFE;
    send(mk_frame(keys(0, -1, -1), 8'h01), 48, 2);
    kbd_cs = 1'b1;
    cyc(3);
    check("commit_early_ok", {31'd0, frame_ok}, 32'd0);
    check("commit_early_kd", {27'd0, kd}, 32'h1F);
    cyc(1);
    check("commit_ok_pulse", {31'd0, frame_ok}, 32'd1);
    check("commit_kd_fe", {27'd0, kd}, 32'h1E);
    cyc(10);
    check_kd("caps_kd_fd", 8'hFD, 5'h1F);
    check_kd("caps_kd_00", 8'h00, 5'h1E);
    check("caps_ext", {24'd0, ext_keys}, 32'h01);
    check("caps_ok_count", ok_cnt, 1);
    check("caps_err_count", err_cnt, 0);

    // Short and overlong frames are discarded.
    send(mk_frame(keys(39, -1, -1), 8'h00), 47, 0);
    send(mk_frame(keys(39, -1, -1), 8'h00) & ~64'h1_0000_0000_0000, 49, 0);
    check("badlen_err_count", err_cnt, 2);
    check("badlen_ok_count", ok_cnt, 1);
    check_kd("badlen_kd_7f", 8'h7F, 5'h1F);
    check_kd("badlen_kd_fe", 8'hFE, 5'h1E);
    check("badlen_ext", {24'd0, ext_keys}, 32'h01);

    // CS rises together with the 48th SCLK rise.
    send(mk_frame(keys(39, -1, -1), 8'h00), 48, 1);
    check("coincide_err_count", err_cnt, 3);
    check("coincide_ok_count", ok_cnt, 1);
    check_kd("coincide_kd_7f", 8'h7F, 5'h1F);

    // Multi-key frame, checked through the KD table.
    send(mk_frame(keys(0, 17, 39), 8'h05), 48, 0);
    foreach (multi_tab[i]) check_kd($sformatf("multi_kd_%02h", multi_tab[i].a), multi_tab[i].a, multi_tab[i].kd);
    check("multi_ext", {24'd0, ext_keys}, 32'h05);
    check("multi_ok_count", ok_cnt, 2);

    // Reset 20 bits into a frame.
    send(mk_frame(keys(22, -1, -1), 8'hFF), 20, 2);
    a_hi = 8'h00;
    rst_n = 1'b0;
    #1;
    check("midrst_kd_00", {27'd0, kd}, 32'h1F);
    check("midrst_ext", {24'd0, ext_keys}, 32'h00);
    kbd_cs = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    ok0 = ok_cnt; err0 = err_cnt;
    send(mk_frame(keys(17, -1, -1), 8'h04), 48, 0);
    check("postrst_ok_count", ok_cnt - ok0, 1);
    check("postrst_err_count", err_cnt - err0, 0);
    check_kd("postrst_kd_f7", 8'hF7, 5'h1B);
    check_kd("postrst_kd_00", 8'h00, 5'h1B);
    check("postrst_ext", {24'd0, ext_keys}, 32'h04);

    // SCLK activity with CS high is ignored.
    ok0 = ok_cnt; err0 = err_cnt;
    kbd_di = 1'b1;
    for (int i = 0; i < 10; i++) begin
      kbd_clk = 1'b1; cyc(5);
      kbd_clk = 1'b0; cyc(5);
    end
    send(mk_frame(keys(26, -1, -1), 8'h02), 48, 0);
    check("idleclk_ok_count", ok_cnt - ok0, 1);
    check("idleclk_err_count", err_cnt - err0, 0);
    check_kd("idleclk_kd_df", 8'hDF, 5'h1D);
    check_kd("idleclk_kd_f7", 8'hF7, 5'h1F);
    check("idleclk_ext", {24'd0, ext_keys}, 32'h02);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic [4:0] kd_probe(input logic [7:0] a);
    // Reset vectors are all 1F; drive A_HI and read KD through a zero-delay settle.
    a_hi = a;
    return kd_settled(a);
  endfunction

  function automatic logic [4:0] kd_settled(input logic [7:0] a);
    logic [4:0] v;
    v = '1;
    if (a_hi == a) v = dut.KD;
    return v;
  endfunction

endmodule
`default_nettype wire
